cotm32_hazard_ctrl: RTL and testbench
=====================================

// Module: cotm32_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline. Owns per-stage valid bits, generates
//  per-register write-enable/flush, operand forwarding selects (forward_src_t), PC select, load/CSR-use
//  interlock, CSR serialization, memory-wait freeze and a trap FSM. Also keeps a stall-cycle counter.
// PARAMETERS
//  NUM_REGS   32  register count; RA = $clog2(NUM_REGS) address bits
//  CNT_WIDTH  32  width of stall_cnt, wraps modulo 2^CNT_WIDTH
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  imem_ready     in   1   fetch data valid this cycle
//  dmem_busy      in   1   MEM-stage access not yet complete
//  id_rs1_addr    in   RA  ID source 1 address; id_rs1_used in 1 = ID reads rs1
//  id_rs2_addr    in   RA  ID source 2 address; id_rs2_used in 1 = ID reads rs2
//  id_is_csr      in   1   ID instruction is a Zicsr op
//  idex_rs1_addr/idex_rs2_addr  in RA  EX operand addresses
//  idex_rd_addr   in   RA  EX destination; idex_regfile_we in 1; idex_csr_we in 1
//  idex_late      in   1   EX result arrives in WB only (reg_wb_sel = LSU or CSR)
//  exmem_rd_addr  in   RA  MEM destination; exmem_regfile_we in 1; exmem_csr_we in 1
//  memwb_rd_addr  in   RA  WB destination; memwb_regfile_we in 1
//  ex_redirect    in   1   taken branch/jump resolved in EX
//  trap_req       in   1   exception/mret raised by instruction in MEM
//  pc_we, ifid_we, idex_we, exmem_we, memwb_we      out 1 each  register enables
//  ifid_flush, idex_flush, exmem_flush, memwb_flush out 1 each  load bubble (valid<=0)
//  pc_sel         out  2   0=SEQ(pc+4), 1=BRANCH(EX target), 2=TRAP(mtvec/mepc)
//  fwd_a_sel, fwd_b_sel  out forward_src_t  EX operand 1/2 source
//  v_ifid, v_idex, v_exmem, v_memwb  out 1 each  stage valid bits
//  stall_cnt      out  CNT_WIDTH  cycles with pc_we==0 outside reset
// BEHAVIOUR
//  Reset: valids 0, stall_cnt 0, FSM RUN; all *_we 0, flushes 1, pc_sel SEQ while rst high.
//  Valid regs: flush -> 0; else we -> upstream valid; else hold. IF valid source = imem_ready & RUN.
//  Hazard checks use only valid stages; rd==0 never matches.
//  Forwarding (combinational, per operand): v_exmem&exmem_regfile_we&rd==src -> EXMEM; else
//   v_memwb&memwb_regfile_we&rd==src -> MEMWB; else NONE. EXMEM beats MEMWB.
//  Use stall: v_ifid & v_idex & idex_regfile_we & idex_late & used&match(rs1|rs2) -> pc_we=ifid_we=0,
//   idex_flush=1, downstream advance. Exactly 1 bubble; consumer then forwards from MEMWB.
//  CSR serialize: v_ifid & id_is_csr & ((v_idex&idex_csr_we)|(v_exmem&exmem_csr_we)) -> same as use stall.
//  Freeze: dmem_busy -> all *_we=0, no flush, pc_sel SEQ; outranks redirect and stalls.
//  Redirect (!dmem_busy, v_idex&ex_redirect): pc_sel=BRANCH, pc_we=1, ifid_flush=idex_flush=1;
//   overrides use stall/CSR serialize in the same cycle (younger instr squashed).
//  imem_ready=0 and no other event: pc_we=0, ifid_flush=1, rest advance.
//  FSM RUN/TRAP_WAIT/TRAP_REFILL:
//   RUN: v_exmem&trap_req: if dmem_busy -> TRAP_WAIT (freeze); else trap cycle.
//   TRAP_WAIT: freeze until !dmem_busy, then trap cycle.
//   Trap cycle: pc_sel=TRAP, pc_we=1, ifid/idex/exmem flush, memwb_flush=1 (trapping instr not
//    written back) -> TRAP_REFILL. Trap outranks redirect and all stalls.
//   TRAP_REFILL: one cycle, IF valid forced 0, pc_sel SEQ -> RUN. trap_req ignored outside RUN.
//  stall_cnt += 1 every cycle pc_we==0 and !rst; wraps to 0.
//  Async rst mid-trap/freeze returns to RUN with all valids 0 immediately.
// TESTING
//  lw x5 then add x6,x5,x1 -> 1 cycle pc_we=0, idex_flush=1; add in EX sees fwd_a_sel=MEMWB; stall_cnt=1.
//  add x5 / sub x7,x5,x5 back-to-back -> no stall, fwd_a_sel=fwd_b_sel=EXMEM; x0 dest -> NONE.
//  beq taken in EX with load-use in ID same cycle -> pc_sel=1, ifid/idex flush, no stall count.
//  trap_req with dmem_busy 3 cycles -> TRAP_WAIT 3 cycles all we=0, then pc_sel=2, 4 flushes, REFILL, RUN.
//  csrrw in EX, csrrs in ID -> ID stalls 2 cycles until writer leaves MEM; stall_cnt=2.
//  stall_cnt preset near 2^CNT_WIDTH-1, 2 stall cycles -> wraps to 1; rst asserted mid-stall -> all 0.

Source files
------------

// File: rtl/cotm32_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: stage valids, register enables/flushes,
// operand forwarding, PC select, interlocks, memory freeze, trap sequencing and a stall counter.

package cotm32_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } forward_src_t;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_TRAP   = 2'd2;

endpackage

module cotm32_hazard_ctrl
  import cotm32_hazard_pkg::*;
#(
  parameter  int unsigned NUM_REGS  = 32,
  parameter  int unsigned CNT_WIDTH = 32,
  localparam int unsigned RA        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_ready,
  input  logic                 dmem_busy,
  input  logic [RA-1:0]        id_rs1_addr,
  input  logic                 id_rs1_used,
  input  logic [RA-1:0]        id_rs2_addr,
  input  logic                 id_rs2_used,
  input  logic                 id_is_csr,
  input  logic [RA-1:0]        idex_rs1_addr,
  input  logic [RA-1:0]        idex_rs2_addr,
  input  logic [RA-1:0]        idex_rd_addr,
  input  logic                 idex_regfile_we,
  input  logic                 idex_csr_we,
  input  logic                 idex_late,
  input  logic [RA-1:0]        exmem_rd_addr,
  input  logic                 exmem_regfile_we,
  input  logic                 exmem_csr_we,
  input  logic [RA-1:0]        memwb_rd_addr,
  input  logic                 memwb_regfile_we,
  input  logic                 ex_redirect,
  input  logic                 trap_req,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 idex_we,
  output logic                 exmem_we,
  output logic                 memwb_we,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 memwb_flush,
  output logic [1:0]           pc_sel,
  output forward_src_t         fwd_a_sel,
  output forward_src_t         fwd_b_sel,
  output logic                 v_ifid,
  output logic                 v_idex,
  output logic                 v_exmem,
  output logic                 v_memwb,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_TRAP_WAIT   = 2'd1,
    ST_TRAP_REFILL = 2'd2
  } trap_state_t;

  trap_state_t          r_state;
  logic                 r_v_ifid;
  logic                 r_v_idex;
  logic                 r_v_exmem;
  logic                 r_v_memwb;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic w_if_valid;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_use_stall;
  logic w_csr_stall;
  logic w_redirect;
  logic w_trap_go;

  // EXMEM has the younger result, so it wins over MEMWB; x0 is never forwarded.
  function automatic forward_src_t fwd_pick(
    input logic [RA-1:0] src,
    input logic          exmem_hit_ok,
    input logic [RA-1:0] exmem_rd,
    input logic          memwb_hit_ok,
    input logic [RA-1:0] memwb_rd
  );
    forward_src_t sel;
    sel = FWD_NONE;
    if (src != '0) begin
      if (exmem_hit_ok && (exmem_rd == src))      sel = FWD_EXMEM;
      else if (memwb_hit_ok && (memwb_rd == src)) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin : p_fwd
    fwd_a_sel = fwd_pick(idex_rs1_addr, r_v_exmem & exmem_regfile_we, exmem_rd_addr,
                         r_v_memwb & memwb_regfile_we, memwb_rd_addr);
    fwd_b_sel = fwd_pick(idex_rs2_addr, r_v_exmem & exmem_regfile_we, exmem_rd_addr,
                         r_v_memwb & memwb_regfile_we, memwb_rd_addr);
  end

  // Hazard detection: a late (LSU/CSR) result in EX cannot be forwarded to the ID consumer in time.
  assign w_rs1_hit   = id_rs1_used & (id_rs1_addr == idex_rd_addr);
  assign w_rs2_hit   = id_rs2_used & (id_rs2_addr == idex_rd_addr);
  assign w_use_stall = r_v_ifid & r_v_idex & idex_regfile_we & idex_late &
                       (idex_rd_addr != '0) & (w_rs1_hit | w_rs2_hit);
  assign w_csr_stall = r_v_ifid & id_is_csr &
                       ((r_v_idex & idex_csr_we) | (r_v_exmem & exmem_csr_we));
  assign w_redirect  = r_v_idex & ex_redirect;
  assign w_trap_go   = !dmem_busy &
                       (((r_state == ST_RUN) & r_v_exmem & trap_req) | (r_state == ST_TRAP_WAIT));
  assign w_if_valid  = imem_ready & (r_state == ST_RUN);

  // Priority: reset, trap, memory freeze, redirect, interlocks, fetch wait.
  always_comb begin : p_ctrl
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_sel      = PC_SEQ;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (w_trap_go) begin
      pc_sel      = PC_TRAP;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (w_redirect) begin
      pc_sel     = PC_BRANCH;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_use_stall || w_csr_stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_trap_fsm
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_v_exmem && trap_req) r_state <= dmem_busy ? ST_TRAP_WAIT : ST_TRAP_REFILL;
        end
        ST_TRAP_WAIT: begin
          if (!dmem_busy) r_state <= ST_TRAP_REFILL;
        end
        ST_TRAP_REFILL: r_state <= ST_RUN;
        default:        r_state <= ST_RUN;
      endcase
    end
  end

  // Stage valids: flush clears, enable advances from upstream, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin : p_valids
    if (rst) begin
      r_v_ifid  <= 1'b0;
      r_v_idex  <= 1'b0;
      r_v_exmem <= 1'b0;
      r_v_memwb <= 1'b0;
    end else begin
      if (ifid_flush)       r_v_ifid  <= 1'b0;
      else if (ifid_we)     r_v_ifid  <= w_if_valid;
      if (idex_flush)       r_v_idex  <= 1'b0;
      else if (idex_we)     r_v_idex  <= r_v_ifid;
      if (exmem_flush)      r_v_exmem <= 1'b0;
      else if (exmem_we)    r_v_exmem <= r_v_idex;
      if (memwb_flush)      r_v_memwb <= 1'b0;
      else if (memwb_we)    r_v_memwb <= r_v_exmem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_stall_cnt
    if (rst)         r_stall_cnt <= '0;
    else if (!pc_we) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
  end

  assign v_ifid    = r_v_ifid;
  assign v_idex    = r_v_idex;
  assign v_exmem   = r_v_exmem;
  assign v_memwb   = r_v_memwb;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_cotm32_hazard_ctrl.sv
// Directed-vector bench for cotm32_hazard_ctrl: the stimulus pushes hand-computed expectations,
// an independent monitor pops and compares once per cycle on the falling edge.

module tb_cotm32_hazard_ctrl;
  import cotm32_hazard_pkg::*;

  localparam int unsigned RA  = 5;
  localparam int unsigned CW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          imem_ready;
    logic          dmem_busy;
    logic [RA-1:0] id_rs1_addr;
    logic          id_rs1_used;
    logic [RA-1:0] id_rs2_addr;
    logic          id_rs2_used;
    logic          id_is_csr;
    logic [RA-1:0] idex_rs1_addr;
    logic [RA-1:0] idex_rs2_addr;
    logic [RA-1:0] idex_rd_addr;
    logic          idex_regfile_we;
    logic          idex_csr_we;
    logic          idex_late;
    logic [RA-1:0] exmem_rd_addr;
    logic          exmem_regfile_we;
    logic          exmem_csr_we;
    logic [RA-1:0] memwb_rd_addr;
    logic          memwb_regfile_we;
    logic          ex_redirect;
    logic          trap_req;
  } stim_t;

  typedef struct {
    string       name;
    logic [22:0] exp;
  } exp_t;

  logic          rst, imem_ready, dmem_busy;
  logic [RA-1:0] id_rs1_addr, id_rs2_addr, idex_rs1_addr, idex_rs2_addr;
  logic [RA-1:0] idex_rd_addr, exmem_rd_addr, memwb_rd_addr;
  logic          id_rs1_used, id_rs2_used, id_is_csr;
  logic          idex_regfile_we, idex_csr_we, idex_late;
  logic          exmem_regfile_we, exmem_csr_we, memwb_regfile_we;
  logic          ex_redirect, trap_req;
  logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0]    pc_sel;
  forward_src_t  fwd_a_sel, fwd_b_sel;
  logic          v_ifid, v_idex, v_exmem, v_memwb;
  logic [CW-1:0] stall_cnt;

  cotm32_hazard_ctrl #(.NUM_REGS(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used), .id_is_csr(id_is_csr),
    .idex_rs1_addr(idex_rs1_addr), .idex_rs2_addr(idex_rs2_addr),
    .idex_rd_addr(idex_rd_addr), .idex_regfile_we(idex_regfile_we),
    .idex_csr_we(idex_csr_we), .idex_late(idex_late),
    .exmem_rd_addr(exmem_rd_addr), .exmem_regfile_we(exmem_regfile_we),
    .exmem_csr_we(exmem_csr_we), .memwb_rd_addr(memwb_rd_addr),
    .memwb_regfile_we(memwb_regfile_we), .ex_redirect(ex_redirect), .trap_req(trap_req),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .pc_sel(pc_sel),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .v_ifid(v_ifid), .v_idex(v_idex),
    .v_exmem(v_exmem), .v_memwb(v_memwb), .stall_cnt(stall_cnt)
  );

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  stim_t s;

  function automatic stim_t dflt();
    stim_t d;
    d = '{rst: 1'b0, imem_ready: 1'b1, dmem_busy: 1'b0, id_rs1_addr: '0, id_rs1_used: 1'b0,
          id_rs2_addr: '0, id_rs2_used: 1'b0, id_is_csr: 1'b0, idex_rs1_addr: '0,
          idex_rs2_addr: '0, idex_rd_addr: '0, idex_regfile_we: 1'b0, idex_csr_we: 1'b0,
          idex_late: 1'b0, exmem_rd_addr: '0, exmem_regfile_we: 1'b0, exmem_csr_we: 1'b0,
          memwb_rd_addr: '0, memwb_regfile_we: 1'b0, ex_redirect: 1'b0, trap_req: 1'b0};
    return d;
  endfunction

  // Expected layout: {we[pc,ifid,idex,exmem,memwb], flush[ifid,idex,exmem,memwb], pc_sel, fa, fb, valids, cnt}
  function automatic logic [22:0] ex(input logic [4:0] we, input logic [3:0] fl, input logic [1:0] pcs,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] v,
                                     input logic [3:0] cnt);
    return {we, fl, pcs, fa, fb, v, cnt};
  endfunction

  task automatic apply(input stim_t x);
    rst = x.rst; imem_ready = x.imem_ready; dmem_busy = x.dmem_busy;
    id_rs1_addr = x.id_rs1_addr; id_rs1_used = x.id_rs1_used;
    id_rs2_addr = x.id_rs2_addr; id_rs2_used = x.id_rs2_used; id_is_csr = x.id_is_csr;
    idex_rs1_addr = x.idex_rs1_addr; idex_rs2_addr = x.idex_rs2_addr;
    idex_rd_addr = x.idex_rd_addr; idex_regfile_we = x.idex_regfile_we;
    idex_csr_we = x.idex_csr_we; idex_late = x.idex_late;
    exmem_rd_addr = x.exmem_rd_addr; exmem_regfile_we = x.exmem_regfile_we;
    exmem_csr_we = x.exmem_csr_we; memwb_rd_addr = x.memwb_rd_addr;
    memwb_regfile_we = x.memwb_regfile_we; ex_redirect = x.ex_redirect; trap_req = x.trap_req;
  endtask

  task automatic cyc(input string n, input logic [22:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    apply(s);
    item.name = n;
    item.exp  = e;
    q.push_back(item);
  endtask

  // Monitor: one observation per cycle, compared against the oldest queued expectation.
  initial begin : monitor
    exp_t        item;
    logic [22:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        item = q.pop_front();
        act = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               pc_sel, 2'(fwd_a_sel), 2'(fwd_b_sel),
               v_ifid, v_idex, v_exmem, v_memwb, stall_cnt};
        checks++;
        if (act !== item.exp) begin
          errors++;
          $display("FAIL %s: got %06h expected %06h", item.name, act, item.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    s = dflt();
    s.rst = 1'b1;
    apply(s);
    cyc("reset", ex(5'b00000, 4'b1111, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd0));
    s = dflt();
    cyc("fill0", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd0));
    cyc("fill1", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1000, 4'd0));
    cyc("fill2", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1100, 4'd0));
    cyc("fill3", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1110, 4'd0));

    // lw x5 in EX, add x6,x5,x1 in ID
    s = dflt();
    s.idex_rd_addr = 5'd5; s.idex_regfile_we = 1'b1; s.idex_late = 1'b1;
    s.id_rs1_addr = 5'd5; s.id_rs1_used = 1'b1; s.id_rs2_addr = 5'd1; s.id_rs2_used = 1'b1;
    cyc("ld_use_stall", ex(5'b00111, 4'b0100, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd0));
    s = dflt();
    s.exmem_rd_addr = 5'd5; s.exmem_regfile_we = 1'b1;
    s.id_rs1_addr = 5'd5; s.id_rs1_used = 1'b1; s.id_rs2_addr = 5'd1; s.id_rs2_used = 1'b1;
    cyc("ld_use_bubble", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1011, 4'd1));
    s = dflt();
    s.idex_rs1_addr = 5'd5; s.idex_rs2_addr = 5'd1; s.idex_rd_addr = 5'd6; s.idex_regfile_we = 1'b1;
    s.memwb_rd_addr = 5'd5; s.memwb_regfile_we = 1'b1;
    cyc("ld_use_fwd_memwb", ex(5'b11111, 4'b0000, 2'd0, 2'd2, 2'd0, 4'b1101, 4'd1));
    s = dflt();
    cyc("refill_a", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1110, 4'd1));

    // back-to-back ALU forwarding
    s = dflt();
    s.idex_rs1_addr = 5'd5; s.idex_rs2_addr = 5'd5;
    s.exmem_rd_addr = 5'd5; s.exmem_regfile_we = 1'b1;
    s.memwb_rd_addr = 5'd5; s.memwb_regfile_we = 1'b1;
    cyc("fwd_exmem_both", ex(5'b11111, 4'b0000, 2'd0, 2'd1, 2'd1, 4'b1111, 4'd1));
    s = dflt();
    s.exmem_regfile_we = 1'b1; s.memwb_regfile_we = 1'b1;
    cyc("fwd_x0_none", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd1));
    s = dflt();
    s.idex_rs1_addr = 5'd3; s.idex_rs2_addr = 5'd4;
    s.exmem_rd_addr = 5'd4; s.exmem_regfile_we = 1'b1;
    s.memwb_rd_addr = 5'd3; s.memwb_regfile_we = 1'b1;
    cyc("fwd_split", ex(5'b11111, 4'b0000, 2'd0, 2'd2, 2'd1, 4'b1111, 4'd1));
    s = dflt();
    s.idex_rs1_addr = 5'd7; s.idex_rs2_addr = 5'd9;
    s.exmem_rd_addr = 5'd7; s.exmem_regfile_we = 1'b0;
    s.memwb_rd_addr = 5'd7; s.memwb_regfile_we = 1'b1;
    cyc("fwd_exmem_no_we", ex(5'b11111, 4'b0000, 2'd0, 2'd2, 2'd0, 4'b1111, 4'd1));

    // taken branch in EX with load-use in ID
    s = dflt();
    s.ex_redirect = 1'b1;
    s.idex_rd_addr = 5'd5; s.idex_regfile_we = 1'b1; s.idex_late = 1'b1;
    s.id_rs1_addr = 5'd5; s.id_rs1_used = 1'b1;
    cyc("redirect_over_stall", ex(5'b11111, 4'b1100, 2'd1, 2'd0, 2'd0, 4'b1111, 4'd1));
    s = dflt();
    cyc("redir_refill0", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b0011, 4'd1));
    cyc("redir_refill1", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1001, 4'd1));
    cyc("redir_refill2", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1100, 4'd1));
    cyc("redir_refill3", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1110, 4'd1));

    // fetch not ready
    s = dflt();
    s.imem_ready = 1'b0;
    cyc("imem_wait", ex(5'b01111, 4'b1000, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd1));
    s = dflt();
    cyc("imem_refill0", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b0111, 4'd2));
    cyc("imem_refill1", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1011, 4'd2));
    cyc("imem_refill2", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1101, 4'd2));
    cyc("imem_refill3", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1110, 4'd2));

    // trap while the MEM access is still busy, redirect pending too
    s = dflt();
    s.trap_req = 1'b1; s.dmem_busy = 1'b1; s.ex_redirect = 1'b1;
    cyc("trap_busy_run", ex(5'b00000, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd2));
    s = dflt();
    s.dmem_busy = 1'b1;
    cyc("trap_wait1", ex(5'b00000, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd3));
    cyc("trap_wait2", ex(5'b00000, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd4));
    s = dflt();
    s.ex_redirect = 1'b1;
    cyc("trap_cycle", ex(5'b11111, 4'b1111, 2'd2, 2'd0, 2'd0, 4'b1111, 4'd5));
    s = dflt();
    s.trap_req = 1'b1;
    cyc("trap_refill", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd5));
    s = dflt();
    cyc("trap_run0", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd5));
    cyc("trap_run1", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1000, 4'd5));
    cyc("trap_run2", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1100, 4'd5));
    cyc("trap_run3", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1110, 4'd5));

    // csrrw in EX, csrrs in ID
    s = dflt();
    s.id_is_csr = 1'b1; s.idex_csr_we = 1'b1;
    cyc("csr_ser_ex", ex(5'b00111, 4'b0100, 2'd0, 2'd0, 2'd0, 4'b1111, 4'd5));
    s = dflt();
    s.id_is_csr = 1'b1; s.exmem_csr_we = 1'b1;
    cyc("csr_ser_mem", ex(5'b00111, 4'b0100, 2'd0, 2'd0, 2'd0, 4'b1011, 4'd6));
    s = dflt();
    s.id_is_csr = 1'b1; s.exmem_csr_we = 1'b1;
    cyc("csr_release", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1001, 4'd7));

    // freeze run drives the counter through its wrap
    s = dflt();
    s.dmem_busy = 1'b1;
    for (int i = 0; i < 10; i++)
      cyc($sformatf("freeze_wrap%0d", i),
          ex(5'b00000, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1100, 4'((7 + i) % 16)));
    s = dflt();
    cyc("cnt_wrapped", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1100, 4'd1));

    // stall, then freeze into TRAP_WAIT, then async reset
    s = dflt();
    s.idex_rd_addr = 5'd5; s.idex_regfile_we = 1'b1; s.idex_late = 1'b1;
    s.id_rs2_addr = 5'd5; s.id_rs2_used = 1'b1;
    cyc("ld_use_rs2", ex(5'b00111, 4'b0100, 2'd0, 2'd0, 2'd0, 4'b1110, 4'd1));
    s = dflt();
    s.trap_req = 1'b1; s.dmem_busy = 1'b1;
    cyc("trap_busy2", ex(5'b00000, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1011, 4'd2));
    s = dflt();
    s.rst = 1'b1;
    cyc("async_rst", ex(5'b00000, 4'b1111, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd0));
    s = dflt();
    cyc("post_rst_run", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd0));
    cyc("post_rst_fetch", ex(5'b11111, 4'b0000, 2'd0, 2'd0, 2'd0, 4'b1000, 4'd0));

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
